// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared types and width helpers for the sequential non-restoring integer
// square-root block.
//   state_t  : controller states (IDLE, CALC, FIX)
//   ROOT_W / REM_W / ACC_W : widths for the default 32-bit radicand
//   root_w() / rem_w() / acc_w() : the same widths for any even radicand width
// -----------------------------------------------------------------------------
package sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int N_DEFAULT = 32;
   localparam int ROOT_W    = N_DEFAULT / 2;
   localparam int REM_W     = N_DEFAULT / 2 + 1;
   localparam int ACC_W     = N_DEFAULT / 2 + 3;

   // Root and iteration count are both half the radicand width.
   function automatic int root_w(input int n);
      return n / 2;
   endfunction

   // Final remainder can reach 2*root, so it needs one bit more than the root.
   function automatic int rem_w(input int n);
      return n / 2 + 1;
   endfunction

   // Signed partial remainder: |R| < 2^(n/2+2) plus a sign bit.
   function automatic int acc_w(input int n);
      return n / 2 + 3;
   endfunction

endpackage

// File: rtl/sqrt_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// sqrt_seq_ctrl_if
// Host-side request/result bundle of the square-root sequencer.
//   start     : single-cycle request, host -> sequencer
//   radicand  : N-bit unsigned operand, host -> sequencer
//   busy      : operation in progress, sequencer -> host
//   done      : one-cycle result-valid pulse, sequencer -> host
//   root      : floor(sqrt(radicand)), N/2 bits
//   remainder : radicand - root*root, N/2+1 bits
// master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface sqrt_seq_ctrl_if #(
   parameter int N = 32
);

   logic             start;
   logic [N-1:0]     radicand;
   logic             busy;
   logic             done;
   logic [N/2-1:0]   root;
   logic [N/2:0]     remainder;

   modport master (
      output start, radicand,
      input  busy, done, root, remainder
   );

   modport slave (
      input  start, radicand,
      output busy, done, root, remainder
   );

endinterface

// File: rtl/sqrt_nr_step.sv
// -----------------------------------------------------------------------------
// sqrt_nr_step
// One combinational digit step of the non-restoring square root.
//   r     : signed partial remainder (two's complement, ACC bits)
//   q     : partial root
//   p     : next radicand bit pair
//   r_nxt : updated partial remainder
//   q_nxt : partial root with the new digit appended
// -----------------------------------------------------------------------------
module sqrt_nr_step
   import sqrt_pkg::*;
#(
   parameter  int N  = 32,
   localparam int QW = root_w(N),
   localparam int AW = acc_w(N)
) (
   input  logic [AW-1:0] r,
   input  logic [QW-1:0] q,
   input  logic [1:0]    p,
   output logic [AW-1:0] r_nxt,
   output logic [QW-1:0] q_nxt
);

   logic [AW-1:0] r_sh;

   // 4R + p; dropping R's top two bits is safe because the final R' fits in
   // AW bits and two's-complement wraparound keeps the low bits exact.
   assign r_sh = {r[AW-3:0], p};

   // The sign bit alone picks subtract (R >= 0) or add (R < 0).
   assign r_nxt = r[AW-1] ? (r_sh + AW'({q, 2'b11}))
                          : (r_sh - AW'({q, 2'b01}));

   // Root digit is 1 when the new remainder is non-negative.
   assign q_nxt = {q[QW-2:0], ~r_nxt[AW-1]};

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_seq_ctrl
// Sequencer for the digit-by-digit non-restoring integer square root. Loads a
// radicand on start, runs N/2 digit steps (one per clock), applies the final
// remainder correction and presents root/remainder with a one-cycle done.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : sqrt_seq_ctrl_if.slave (start, radicand, busy, done, root,
//           remainder)
// -----------------------------------------------------------------------------
module sqrt_seq_ctrl
   import sqrt_pkg::*;
#(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           reset,
   sqrt_seq_ctrl_if.slave bus
);

   localparam int QW = root_w(N);
   localparam int MW = rem_w(N);
   localparam int AW = acc_w(N);
   localparam int CW = $clog2(QW);

   state_t        state;
   logic [N-1:0]  d;
   logic [QW-1:0] q;
   logic [AW-1:0] r;
   logic [CW-1:0] cnt;

   logic [AW-1:0] r_nxt;
   logic [QW-1:0] q_nxt;
   logic [AW-1:0] r_fix;

   sqrt_nr_step #(.N(N)) u_step (
      .r     (r),
      .q     (q),
      .p     (d[N-1:N-2]),
      .r_nxt (r_nxt),
      .q_nxt (q_nxt)
   );

   // A negative final remainder is one step past the answer; adding 2Q+1
   // restores it to radicand - root^2.
   assign r_fix = r[AW-1] ? (r + AW'({q, 1'b1})) : r;

   // NOTE: every state register here is a flop and is assigned with <=, so
   // all right-hand sides read the values from before this edge.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: all registers, including the iteration state, are cleared so an
      // aborted operation leaves nothing behind.
      if (reset) begin
         state         <= IDLE;
         d             <= '0;
         q             <= '0;
         r             <= '0;
         cnt           <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.root      <= '0;
         bus.remainder <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  d        <= bus.radicand;
                  q        <= '0;
                  r        <= '0;
                  cnt      <= CW'(QW - 1);
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               d <= {d[N-3:0], 2'b00};
               r <= r_nxt;
               q <= q_nxt;
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            FIX: begin
               r             <= r_fix;
               bus.root      <= q;
               bus.remainder <= r_fix[MW-1:0];
               bus.done      <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqrt_seq_ctrl
// Self-checking bench for sqrt_seq_ctrl (N = 32). Expected roots come from an
// arithmetic floor-sqrt model; latency, busy width, output hold, ignored start,
// back-to-back start and asynchronous abort are checked directly.
// -----------------------------------------------------------------------------
module tb_sqrt_seq_ctrl;
   import sqrt_pkg::*;

   localparam int N   = N_DEFAULT;
   localparam int LAT = N / 2 + 1;

   logic clk;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ROOT_W-1:0] last_root;
   logic [REM_W-1:0]  last_rem;

   sqrt_seq_ctrl_if #(.N(N)) bus ();

   sqrt_seq_ctrl #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: largest r with r*r <= x, and x - r*r.
   task automatic ref_sqrt(input logic [31:0] x, output logic [63:0] rt, output logic [63:0] rm);
      longint unsigned v;
      longint unsigned s;
      v = 64'(x);
      s = longint'($sqrt(real'(v)));
      while (s * s > v) s--;
      while ((s + 1) * (s + 1) <= v) s++;
      rt = s;
      rm = v - s * s;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after an edge; the next edge accepts the request.
   task automatic launch(input logic [31:0] x);
      bus.start    = 1'b1;
      bus.radicand = x;
      step();
      bus.start    = 1'b0;
      bus.radicand = $urandom;
   endtask

   // Waits for done, counting cycles and busy cycles, and tallies any change
   // of the result outputs before done.
   task automatic wait_done(output int cyc, output int bc, output int hold_bad);
      cyc      = 0;
      bc       = 0;
      hold_bad = 0;
      while (bus.done !== 1'b1 && cyc < 60) begin
         if (bus.busy === 1'b1) bc++;
         if (bus.root !== last_root || bus.remainder !== last_rem) hold_bad++;
         step();
         cyc++;
      end
   endtask

   task automatic check_result(input string tag, input logic [31:0] x);
      logic [63:0] rt;
      logic [63:0] rm;
      ref_sqrt(x, rt, rm);
      check({tag, " root"}, 64'(bus.root), rt);
      check({tag, " rem"}, 64'(bus.remainder), rm);
      last_root = rt[ROOT_W-1:0];
      last_rem  = rm[REM_W-1:0];
   endtask

   task automatic do_op(input string tag, input logic [31:0] x);
      int cyc;
      int bc;
      int hb;
      launch(x);
      wait_done(cyc, bc, hb);
      check({tag, " latency"}, 64'(cyc), 64'(LAT));
      check({tag, " busy cycles"}, 64'(bc), 64'(LAT));
      check({tag, " hold"}, 64'(hb), 64'(0));
      check_result(tag, x);
   endtask

   task automatic count_done(input int cycles, output int dn);
      dn = 0;
      for (int i = 0; i < cycles; i++) begin
         if (bus.done === 1'b1) dn++;
         step();
      end
   endtask

   initial begin
      int cyc;
      int bc;
      int hb;
      int dn;
      logic [31:0] x;

      last_root    = '0;
      last_rem     = '0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.radicand = '0;
      repeat (2) step();

      check("reset busy", 64'(bus.busy), 64'(0));
      check("reset done", 64'(bus.done), 64'(0));
      check("reset root", 64'(bus.root), 64'(0));
      check("reset rem", 64'(bus.remainder), 64'(0));

      reset = 1'b0;
      step();

      // Directed values including the all-ones boundary.
      do_op("r0", 32'd0);
      do_op("r1", 32'd1);
      do_op("r15", 32'd15);
      do_op("r16", 32'd16);
      do_op("r1e6", 32'd1000000);
      do_op("rmax", 32'hFFFF_FFFF);
      check("rmax root const", 64'(bus.root), 64'd65535);
      check("rmax rem const", 64'(bus.remainder), 64'd131070);

      // Random radicands: full range and perfect-square neighbourhoods.
      for (int i = 0; i < 6; i++) begin
         x = $urandom;
         do_op("rand", x);
         x = $urandom_range(65535);
         x = x * x + 32'($urandom_range(2)) - 32'd1;
         do_op("rand sq", x);
      end

      // Second start during an operation is ignored.
      x = 32'd12345678;
      launch(x);
      repeat (4) step();
      bus.start    = 1'b1;
      bus.radicand = 32'd777;
      step();
      bus.start = 1'b0;
      wait_done(cyc, bc, hb);
      check("ign latency", 64'(cyc), 64'(LAT - 5));
      check("ign hold", 64'(hb), 64'(0));
      check_result("ign", x);
      step();
      count_done(30, dn);
      check("ign no second done", 64'(dn), 64'(0));
      check("ign idle busy", 64'(bus.busy), 64'(0));

      // Start in the done cycle is accepted; previous result holds meanwhile.
      do_op("b2b first", 32'd50);
      check("b2b done cycle", 64'(bus.done), 64'(1));
      do_op("b2b second", 32'd99);
      check("b2b root9", 64'(bus.root), 64'd9);
      check("b2b rem18", 64'(bus.remainder), 64'd18);

      // Asynchronous abort at cycle 8.
      launch(32'hDEAD_BEEF);
      repeat (8) step();
      #2;
      reset = 1'b1;
      #1;
      check("abort busy", 64'(bus.busy), 64'(0));
      check("abort done", 64'(bus.done), 64'(0));
      check("abort root", 64'(bus.root), 64'(0));
      check("abort rem", 64'(bus.remainder), 64'(0));
      step();
      reset     = 1'b0;
      last_root = '0;
      last_rem  = '0;
      count_done(30, dn);
      check("abort no done", 64'(dn), 64'(0));
      check("abort busy idle", 64'(bus.busy), 64'(0));
      do_op("after abort", $urandom);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sqrt_seq_ctrl.md
Name: sqrt_seq_ctrl

Overview:
Sequencer for the digit-by-digit, non-restoring integer square root. It loads a radicand on a start pulse and runs one partial-root step per clock: shift in the next radicand bit pair, then add or subtract the trial term. The sign of the partial remainder decides each root digit. After all digits it applies a final remainder correction and presents root and remainder with a one-cycle done pulse. It sits between a host or register interface and the per-digit datapath, and owns all iteration state.

Parameters:
N, 32, radicand width in bits; must be even and at least 4. Root width is N/2; iteration count is N/2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; sampled only when busy=0
radicand  input  N  unsigned value; sampled on the edge that accepts start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when root and remainder are valid
root  output  N/2  floor(sqrt(radicand))
remainder  output  N/2+1  radicand - root*root; maximum 2*root

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset is high:
  - state=IDLE, busy=0, done=0, root=0, remainder=0.
  - All internal registers (D, Q, R, cnt) are cleared.
- Internal registers:
  - D: N-bit shift register holding the radicand.
  - Q: N/2-bit partial root.
  - R: signed partial remainder, N/2+3 bits.
  - cnt: iteration counter, $clog2(N/2) bits.
- IDLE:
  - If start=1, load D=radicand, Q=0, R=0, cnt=N/2-1; go to CALC; busy=1 from the next cycle.
  - Otherwise stay in IDLE. done is low except for its single pulse cycle.
- CALC, one step per clock:
  - p = top two bits of D; then D shifts left by 2.
  - If R>=0: R' = 4R + p - (4Q+1). Otherwise: R' = 4R + p + (4Q+3).
  - Q' = {Q[N/2-2:0], ~R'[msb]}. This is the per-digit sign check: digit 1 if R'>=0.
  - If cnt==0, go to FIX; otherwise cnt-1.
- FIX, one cycle:
  - If R<0, R += 2Q+1.
  - root<=Q, remainder<=R[N/2:0], done<=1, busy<=0, then go to IDLE.
- Latency: start accepted at edge e0. Steps run at e1..eN/2, FIX at eN/2+1. done is high in the cycle after edge N/2+1, i.e. 17 cycles after e0 for N=32.
- root and remainder are registered. They hold their value until the next FIX; they do not change at start.
- start while busy=1 is ignored. It is not queued and radicand is not sampled.
- start in the same cycle as done=1 is accepted, since state is already IDLE. Back-to-back throughput is 1 result per N/2+2 cycles.
- Reset mid-operation aborts immediately. No done pulse is produced, and root/remainder return to 0.
- R never overflows: |R| < 2^(N/2+2). Arithmetic is two's complement, and the add/sub choice uses R's sign bit only.

Decomposition:
- Package sqrt_pkg:
  - typedef enum state_t {IDLE, CALC, FIX}.
  - Localparam helpers ROOT_W=N/2 and REM_W=N/2+1.
- Sub-module sqrt_nr_step (combinational): inputs R, Q, p; outputs R', Q'. It contains the add/sub and the sign-to-digit decision. The controller instantiates it once and keeps the FSM, counter and registers.

Test Plan:
- radicand=0 -> root=0, remainder=0. done exactly 17 cycles after start; busy high for 17 cycles.
- radicand=1, then 15, then 16 -> (1,0), (3,6), (4,0).
- radicand=1000000 -> root=1000, remainder=0. radicand=0xFFFFFFFF -> root=65535, remainder=131070.
- start pulsed again at cycle 5 of an operation with a different radicand -> ignored. First result unchanged; no second done.
- start asserted in the done cycle with radicand=99 -> accepted. Next done gives root=9, remainder=18. The previous outputs hold until then.
- Assert reset at cycle 8 of an operation -> busy=0, done=0, root=0, remainder=0 asynchronously. No done after reset is released. A new start works normally.
